// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 scan-code decode path.
package kbd_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} kbd_state_e;
endpackage

// File: rtl/scan2ascii.sv
// Combinational set-2 scan code to lowercase ASCII lookup; extended codes map to 00.
module scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       ext,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      case (scan_code)
        8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
        8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
        8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
        8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
        8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
        8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
        8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
        8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
        8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
        8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        SC_SPACE: ascii = 8'h20;
        SC_ENTER: ascii = 8'h0D;
        default:  ascii = 8'h00;
      endcase
    end
  end
endmodule

// File: rtl/kbd_scan_decoder.sv
// Pops bytes from the PS/2 FIFO, tracks E0/F0 prefixes and key state,
// and produces make/break strobes, ASCII and a wrapping press count.
module kbd_scan_decoder
  import kbd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       scan_code,
  output logic             ext,
  output logic [7:0]       ascii,
  output logic             key_down,
  output logic             make_pulse,
  output logic             break_pulse,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_seen
);
  logic       pop_q;
  logic [7:0] byte_q;
  kbd_state_e state, nxt_state;
  logic       ev_make, ev_brk, ev_ext, same_key;
  logic [7:0] ascii_nxt;

  // Classify the captured byte against the prefix state.
  always_comb begin
    nxt_state = state;
    ev_make   = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;
    case (state)
      S_IDLE: begin
        if (byte_q == SC_EXT)      nxt_state = S_EXT;
        else if (byte_q == SC_BRK) nxt_state = S_BRK;
        else                       ev_make   = 1'b1;
      end
      S_EXT: begin
        ev_ext = 1'b1;
        if (byte_q == SC_BRK)      nxt_state = S_EXTBRK;
        else if (byte_q != SC_EXT) begin
          ev_make   = 1'b1;
          nxt_state = S_IDLE;
        end
      end
      S_BRK: begin
        ev_brk    = 1'b1;
        nxt_state = S_IDLE;
      end
      S_EXTBRK: begin
        ev_brk    = 1'b1;
        ev_ext    = 1'b1;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign same_key = (scan_code == byte_q) && (ext == ev_ext);

  scan2ascii u_s2a (
    .scan_code (byte_q),
    .ext       (ev_ext),
    .ascii     (ascii_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pop_q       <= 1'b0;
      byte_q      <= 8'h00;
      state       <= S_IDLE;
      nextdata_n  <= 1'b1;
      scan_code   <= 8'h00;
      ext         <= 1'b0;
      ascii       <= 8'h00;
      key_down    <= 1'b0;
      make_pulse  <= 1'b0;
      break_pulse <= 1'b0;
      press_cnt   <= '0;
      ovf_seen    <= 1'b0;
    end else begin
      make_pulse  <= 1'b0;
      break_pulse <= 1'b0;
      if (overflow) ovf_seen <= 1'b1;
      if (pop_q) begin
        nextdata_n <= 1'b1;
        pop_q      <= 1'b0;
        state      <= nxt_state;
        // A make matching the held key is typematic repeat: no state change.
        if (ev_make && !(key_down && same_key)) begin
          scan_code  <= byte_q;
          ext        <= ev_ext;
          ascii      <= ascii_nxt;
          key_down   <= 1'b1;
          make_pulse <= 1'b1;
          press_cnt  <= press_cnt + CNT_W'(1);
        end
        if (ev_brk) begin
          break_pulse <= 1'b1;
          if (same_key) key_down <= 1'b0;
        end
      end else if (ready) begin
        byte_q     <= data;
        nextdata_n <= 1'b0;
        pop_q      <= 1'b1;
      end
    end
  end
endmodule

// File: doc/kbd_scan_decoder.md
# kbd_scan_decoder

Consumes the byte stream from the PS/2 keyboard receiver FIFO. Tracks make/break (`F0`) and extended (`E0`) prefixes, holds the current key state, maps scan codes to ASCII, and counts key presses. Its outputs drive the seven-segment display and the LEDs. It sits directly downstream of `ps2_keyboard` and pops that block's FIFO through the `ready`/`nextdata_n` handshake.

## Interface
- `CNT_W`, default 8: width of the press counter.
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `data` in 8: FIFO head byte from `ps2_keyboard`.
- `ready` in 1: FIFO non-empty; `data` is valid.
- `overflow` in 1: FIFO overflow flag from `ps2_keyboard`.
- `nextdata_n` out 1: active-low pop strobe to the FIFO.
- `scan_code` out 8: last make code accepted, without prefix.
- `ext` out 1: `scan_code` was `E0`-prefixed.
- `ascii` out 8: lowercase ASCII of `scan_code`; `00` if unmapped or if `ext`=1.
- `key_down` out 1: the key in `scan_code`/`ext` is currently held.
- `make_pulse` out 1: one-cycle strobe on each new (non-repeat) press.
- `break_pulse` out 1: one-cycle strobe on any completed break sequence.
- `press_cnt` out CNT_W: count of new presses; wraps.
- `ovf_seen` out 1: sticky; set when `overflow`=1 is sampled.

## Operation
- **Pop handshake.**
  - The block captures a byte at a rising edge when `ready`=1 and `pop_q`=0: `data` goes to `byte_q`, `nextdata_n`←0, `pop_q`←1.
  - On the next edge: `nextdata_n`←1, `pop_q`←0, and `byte_q` is decoded.
  - `nextdata_n` is therefore low for exactly one cycle, and a new capture cannot occur while `pop_q`=1. Maximum rate is one byte per 2 cycles.
- **Prefix FSM.** States are S_IDLE, S_BRK, S_EXT, S_EXTBRK. On each decoded byte:
  - S_IDLE: `E0`→S_EXT; `F0`→S_BRK; any other byte is a make (ext=0), then S_IDLE.
  - S_EXT: `F0`→S_EXTBRK; `E0` stays in S_EXT; any other byte is a make (ext=1), then S_IDLE.
  - S_BRK: any byte is a break (ext=0), then S_IDLE.
  - S_EXTBRK: any byte is a break (ext=1), then S_IDLE.
- **Make {c,e}.**
  - Repeat case: if `key_down`=1, `scan_code`=c and `ext`=e, this is typematic repeat. Nothing changes and no pulse is generated.
  - Otherwise: `scan_code`←c, `ext`←e, `key_down`←1, `make_pulse`←1, `press_cnt`←`press_cnt`+1 mod 2^CNT_W.
- **Break {c,e}.**
  - `break_pulse`←1 in all cases.
  - `key_down`←0 only if {c,e} matches {`scan_code`,`ext`}. A break for a different key leaves all state unchanged.
- **ASCII.** Combinational from `scan_code`/`ext`.
  - Covers letters a–z, digits 0–9, space (`29`→`20`), enter (`5A`→`0D`).
  - Everything else, and any code with `ext`=1, gives `00`.
  - `ascii` is registered alongside `scan_code`, so both update on the same edge.
- **Overflow.** `ovf_seen`←1 whenever `overflow`=1 is sampled. It clears only on reset.

## Timing
- Reset (async, `resetn`=0): every output is 0 except `nextdata_n`=1. The FSM goes to S_IDLE and `pop_q`=0.
- Latency: `ready` sampled high at edge N → `nextdata_n` low during cycle N..N+1 → outputs and pulses update at edge N+1, and the pulses are high for one cycle.
- `make_pulse` and `break_pulse` are never high together. Each is high for exactly one cycle per event.
- Prefix bytes (`E0`, `F0`) produce no output change other than the FSM state.
- `ready` dropping while `pop_q`=1 is legal; the captured byte is still decoded.
- If reset is asserted in the middle of a sequence (for example after `F0`), the FSM returns to S_IDLE. The next non-prefix byte is then treated as a make.
- `press_cnt` wraps from 2^CNT_W−1 to 0 with no flag.

## Structure
- Package `kbd_pkg`:
  - Constants `SC_EXT`=8'hE0 and `SC_BRK`=8'hF0.
  - The FSM state enum (2 bits).
  - The scan-code constants for space and enter.
- Sub-module `scan2ascii`: purely combinational lookup (`scan_code`, `ext` → `ascii`). It is reusable by the VGA text path.
- Top-level RTL contains the handshake register, the FSM, the key-state registers, the counter and the pulse registers.

## Test plan
1. Bytes `1C`,`F0`,`1C` → `scan_code`=1C, `ascii`=61. One `make_pulse`, then `key_down`=0 with one `break_pulse`. `press_cnt`=1.
2. Bytes `1C`,`1C`,`1C`,`F0`,`1C` (typematic repeat) → `press_cnt`=1, exactly one `make_pulse`, exactly one `break_pulse`.
3. Bytes `E0`,`75`,`E0`,`F0`,`75` → `ext`=1, `scan_code`=75, `ascii`=00. `key_down` goes 1 then 0.
4. Hold `ready`=1 with 4 queued bytes → `nextdata_n` pulses low exactly 4 times, each pulse one cycle wide, with pulses 2 cycles apart.
5. 256 make/break pairs alternating `1C`/`32` → `press_cnt` wraps to 0. Assert `overflow` for 1 cycle → `ovf_seen`=1 until reset.
6. Send `F0`, assert `resetn`=0 for 1 cycle, then send `45` → all outputs are reset, then `scan_code`=45, `ascii`=30, `key_down`=1, `press_cnt`=1.
